spi_main: RTL and testbench

- SPI controller (main) for the 44-bit lab SPI protocol. It is the initiator-side counterpart of `spi_sub`.
- Accepts one read/write request per transaction from a host-side valid/ready interface and serialises frame {op[1:0], addr[9:0], data[31:0]} MSB-first on `mosi`.
- Waits the fixed turnaround, then deserialises the 44-bit response from `miso` and returns it on a one-cycle response strobe.
- Shares `sclk` with `spi_sub`; `sclk` is the single system clock.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_shift44.sv | 39 +++
 rtl/spi_main.sv | 186 ++++++++++++++++++
 tb/tb_spi_main.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the 44-bit lab SPI protocol.
// Frame layout (MSB first): {op[1:0], addr[9:0], data[31:0]}.
package spi_pkg;

  localparam int FRAME_W = 44;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;

  typedef logic [1:0] spi_op_t;

  localparam spi_op_t OP_READ  = 2'b00;
  localparam spi_op_t OP_WRITE = 2'b01;

  typedef struct packed {
    spi_op_t             op;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
  } spi_frame_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_TURN,
    ST_RECV,
    ST_GAP
  } spi_main_state_e;

endpackage

// File: rtl/spi_shift44.sv
// Combined tx/rx shift register for one SPI frame plus a 6-bit phase counter.
// The same register shifts the request out (MSB first) and the response in.
module spi_shift44
  import spi_pkg::*;
(
  input  logic               sclk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_val,
  input  logic               shift_en,
  input  logic               din,
  input  logic               cnt_load,
  input  logic [5:0]         cnt_init,
  input  logic               cnt_dec,
  output logic [FRAME_W-1:0] q,
  output logic [5:0]         cnt
);

  // Frame register: parallel load on handshake, shift left inserting miso otherwise.
  always_ff @(posedge sclk) begin
    if (load) begin
      q <= load_val;
    end else if (shift_en) begin
      q <= {q[FRAME_W-2:0], din};
    end
  end

  // Phase counter: reloaded at each state entry, counts down to zero.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_load) begin
      cnt <= cnt_init;
    end else if (cnt_dec) begin
      cnt <= cnt - 6'd1;
    end
  end

endmodule

// File: rtl/spi_main.sv
// SPI main (initiator) for the 44-bit lab protocol.
// IDLE -> SEND (44 bits) -> TURN -> RECV (44 bits) -> completion -> GAP -> IDLE.
// Optional build macro SPI_MAIN_CHECK_EN: flags header/write-echo mismatches on rsp_err.
module spi_main
  import spi_pkg::*;
#(
  parameter int TURN_CYCLES = 2,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                sclk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [FRAME_W-1:0]  rsp_frame,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output logic                cs_n,
  output logic                mosi,
  input  logic                miso
);

  // TURN spans TURN_CYCLES-1 cycles in its own state; the SEND exit edge counts as the first.
  localparam logic [5:0] SEND_LOAD = 6'(FRAME_W - 1);
  localparam logic [5:0] RECV_LOAD = 6'(FRAME_W);
  localparam logic [5:0] TURN_LOAD = 6'((TURN_CYCLES > 1) ? (TURN_CYCLES - 2) : 0);
  localparam logic [5:0] GAP_LOAD  = 6'(GAP_CYCLES - 1);

  spi_main_state_e    state, state_nxt;
  spi_frame_t         req_frame;
  logic               load, shift_en, cnt_load, cnt_dec, done;
  logic [5:0]         cnt_init, cnt;
  logic [FRAME_W-1:0] shreg;

  assign req_frame = '{op: spi_op_t'(req_op), addr: req_addr, data: req_wdata};
  assign req_ready = rst_n && (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_rdata = rsp_frame[DATA_W-1:0];

  spi_shift44 u_shift (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (req_frame),
    .shift_en (shift_en),
    .din      (miso),
    .cnt_load (cnt_load),
    .cnt_init (cnt_init),
    .cnt_dec  (cnt_dec),
    .q        (shreg),
    .cnt      (cnt)
  );

  // State register.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control; in RECV the counter runs 44..1 while sampling, 0 is completion.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    cnt_load  = 1'b0;
    cnt_init  = '0;
    cnt_dec   = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt = ST_SEND;
          load      = 1'b1;
          cnt_load  = 1'b1;
          cnt_init  = SEND_LOAD;
        end
      end
      ST_SEND: begin
        shift_en = 1'b1;
        if (cnt == '0) begin
          cnt_load = 1'b1;
          if (TURN_CYCLES > 1) begin
            state_nxt = ST_TURN;
            cnt_init  = TURN_LOAD;
          end else begin
            state_nxt = ST_RECV;
            cnt_init  = RECV_LOAD;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_TURN: begin
        if (cnt == '0) begin
          state_nxt = ST_RECV;
          cnt_load  = 1'b1;
          cnt_init  = RECV_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RECV: begin
        if (cnt == '0) begin
          state_nxt = ST_GAP;
          done      = 1'b1;
          cnt_load  = 1'b1;
          cnt_init  = GAP_LOAD;
        end else begin
          shift_en = 1'b1;
          cnt_dec  = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // mosi launches on the falling edge so the sub sees a stable bit at the next rising edge.
  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      mosi <= 1'b0;
    end else begin
      mosi <= (state == ST_SEND) ? shreg[FRAME_W-1] : 1'b0;
    end
  end

  // Chip select and response strobe/capture.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_frame <= '0;
    end else begin
      rsp_valid <= done;
      if (load) begin
        cs_n <= 1'b0;
      end
      if (done) begin
        cs_n      <= 1'b1;
        rsp_frame <= shreg;
      end
    end
  end

`ifdef SPI_MAIN_CHECK_EN
  spi_frame_t sent_q;
  spi_frame_t rx_f;
  logic       err_q;

  assign rx_f    = spi_frame_t'(shreg);
  assign rsp_err = err_q;

  // Copy of the transmitted frame, kept for the echo comparison.
  always_ff @(posedge sclk) begin
    if (load) begin
      sent_q <= req_frame;
    end
  end

  // Echo check: header must match; write data must also match for writes.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (done) begin
      err_q <= (rx_f.op != sent_q.op) || (rx_f.addr != sent_q.addr) ||
               ((sent_q.op == OP_WRITE) && (rx_f.data != sent_q.data));
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_main.sv
// Directed bench for spi_main with a behavioural spi_sub + memory model.
module tb_spi_main;

`ifdef SPI_MAIN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        sclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [43:0] rsp_frame;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        cs_n;
  logic        mosi;
  logic        miso = 1'b0;

  int checks = 0;
  int errors = 0;

  spi_main dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_frame (rsp_frame),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso)
  );

  always #5 sclk = ~sclk;

  // ---------------- sub model ----------------
  logic [31:0] mem [0:1023] = '{default: 32'h0};
  logic [43:0] sub_sh = '0;
  logic [43:0] sub_rx = '0;
  logic [43:0] sub_rsp = '0;
  logic        sub_first = 1'b0;
  bit          flip35 = 1'b0;
  int          sub_e = 0;

  function automatic logic [43:0] sub_reply(input logic [43:0] f);
    logic [43:0] r;
    r = f;
    if (f[43:42] == 2'b00) begin
      r = {f[43:32], mem[f[41:32]]};
      if (flip35) r = r ^ 44'h00800000000;
    end
    return r;
  endfunction

  always @(posedge sclk) begin
    if (cs_n) begin
      sub_e <= 0;
    end else begin
      sub_e <= sub_e + 1;
      if (sub_e == 0) sub_first <= mosi;
      if (sub_e < 44) sub_sh <= {sub_sh[42:0], mosi};
      if (sub_e == 43) begin
        sub_rx  <= {sub_sh[42:0], mosi};
        sub_rsp <= sub_reply({sub_sh[42:0], mosi});
        if (sub_sh[42:41] == 2'b01) mem[sub_sh[40:31]] <= {sub_sh[30:0], mosi};
      end
    end
  end

  always @(negedge sclk) begin
    if (!cs_n && sub_e >= 45 && sub_e <= 88) miso <= sub_rsp[88 - sub_e];
    else miso <= 1'b0;
  end

  // ---------------- timing monitors ----------------
  int low_run = 0, last_low = 0, high_run = 0, last_high = 0;
  int rsp_pulses = 0, rdy_viol = 0;

  always @(posedge sclk) begin
    if (!cs_n) low_run <= low_run + 1;
    else if (low_run != 0) begin last_low <= low_run; low_run <= 0; end
    if (cs_n) high_run <= high_run + 1;
    else if (high_run != 0) begin last_high <= high_run; high_run <= 0; end
    if (rsp_valid) rsp_pulses <= rsp_pulses + 1;
    if (!cs_n && req_ready) rdy_viol <= rdy_viol + 1;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic handshake(input logic [1:0] op, input logic [9:0] a, input logic [31:0] d,
                           input bit hold);
    int n;
    req_op = op; req_addr = a; req_wdata = d; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 300) begin @(posedge sclk); #1; n++; end
    if (!req_ready) chk("ready_timeout", 64'd0, 64'd1);
    @(posedge sclk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 300) begin @(posedge sclk); #1; n++; end
    if (!rsp_valid) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic txn(input string tag, input logic [1:0] op, input logic [9:0] a,
                     input logic [31:0] d, input logic [43:0] exp_f, input bit exp_e);
    handshake(op, a, d, 1'b0);
    wait_rsp(tag);
    chk({tag, "_frame"}, 64'(rsp_frame), 64'(exp_f));
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_f[31:0]));
    chk({tag, "_err"}, 64'(rsp_err), 64'(exp_e));
    chk({tag, "_csn_at_rsp"}, 64'(cs_n), 64'd1);
    @(posedge sclk); #1;
    chk({tag, "_pulse_end"}, 64'(rsp_valid), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    chk("rst_csn", 64'(cs_n), 64'd1);
    chk("rst_mosi", 64'(mosi), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rspv", 64'(rsp_valid), 64'd0);
    chk("rst_frame", 64'(rsp_frame), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    rst_n = 1'b1;
    @(posedge sclk); #1;
    chk("idle_ready", 64'(req_ready), 64'd1);

    // write / read basics
    txn("wr010", 2'b01, 10'h010, 32'hDEADBEEF, 44'h410DEADBEEF, 1'b0);
    chk("wr010_low90", 64'(last_low), 64'd90);
    chk("wr010_mem", 64'(mem[10'h010]), 64'hDEADBEEF);
    chk("wr010_subrx", 64'(sub_rx), 64'h410DEADBEEF);
    chk("wr010_first", 64'(sub_first), 64'd0);
    chk("mosi_idle", 64'(mosi), 64'd0);
    chk("ready_low_in_frame", 64'(rdy_viol), 64'd0);

    txn("rd010", 2'b00, 10'h010, 32'h0, 44'h010DEADBEEF, 1'b0);
    chk("rd010_subrx", 64'(sub_rx), 64'h01000000000);
    txn("wr020", 2'b01, 10'h020, 32'h12345678, 44'h42012345678, 1'b0);
    txn("rd020", 2'b00, 10'h020, 32'h0, 44'h02012345678, 1'b0);
    txn("rd010b", 2'b00, 10'h010, 32'h0, 44'h010DEADBEEF, 1'b0);

    // back-to-back with req_valid held
    p0 = rsp_pulses;
    handshake(2'b01, 10'h040, 32'hCAFEF00D, 1'b1);
    req_op = 2'b00; req_addr = 10'h040; req_wdata = 32'h0;
    wait_rsp("b2b1");
    chk("b2b1_frame", 64'(rsp_frame), 64'h440CAFEF00D);
    @(posedge sclk); #1;
    begin
      int n;
      n = 0;
      while (!req_ready && n < 300) begin @(posedge sclk); #1; n++; end
      if (!req_ready) chk("b2b_ready_timeout", 64'd0, 64'd1);
    end
    @(posedge sclk); #1;
    req_valid = 1'b0;
    wait_rsp("b2b2");
    chk("b2b2_frame", 64'(rsp_frame), 64'h040CAFEF00D);
    @(posedge sclk); #1;
    chk("b2b_gap3", 64'(last_high), 64'd3);
    chk("b2b_pulses", 64'(rsp_pulses - p0), 64'd2);

    // reset mid-frame
    handshake(2'b01, 10'h030, 32'h11111111, 1'b0);
    repeat (20) @(posedge sclk);
    #1;
    chk("abort_busy_before", 64'(busy), 64'd1);
    p0 = rsp_pulses;
    rst_n = 1'b0;
    #1;
    chk("abort_csn", 64'(cs_n), 64'd1);
    chk("abort_rspv", 64'(rsp_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(req_ready), 64'd0);
    @(posedge sclk); @(posedge sclk); #1;
    rst_n = 1'b1;
    repeat (120) @(posedge sclk);
    #1;
    chk("abort_no_rsp", 64'(rsp_pulses - p0), 64'd0);
    chk("abort_mem", 64'(mem[10'h030]), 64'd0);
    txn("wr030", 2'b01, 10'h030, 32'h55AA55AA, 44'h43055AA55AA, 1'b0);
    txn("rd030", 2'b00, 10'h030, 32'h0, 44'h03055AA55AA, 1'b0);

    // corrupted read echo, then clean write
    flip35 = 1'b1;
    txn("rdflip", 2'b00, 10'h010, 32'h0, 44'h018DEADBEEF, CHK);
    flip35 = 1'b0;
    txn("wr050", 2'b01, 10'h050, 32'hA5A5A5A5, 44'h450A5A5A5A5, 1'b0);

    // reserved op passes through unchanged
    txn("op10", 2'b10, 10'h3FF, 32'h0F0F0F0F, 44'hBFF0F0F0F0F, 1'b0);
    chk("op10_first", 64'(sub_first), 64'd1);
    chk("ready_low_all", 64'(rdy_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
